// File: rtl/mem_arbiter.sv
// Two-requester line-burst arbiter: the instruction and data caches share one word-addressed memory port.
// Round-robin on ties. Each burst is followed by one idle GAP cycle so the memory enables always drop between transactions.
module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int BW        = $clog2(BURST_LEN)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IC_REQ,
  input  logic [31:0]   IC_ADDR,
  output logic          IC_VALID,
  output logic [31:0]   IC_DATA,
  output logic [BW-1:0] IC_BEAT,
  output logic          IC_DONE,
  input  logic          DC_REQ,
  input  logic          DC_WE,
  input  logic [31:0]   DC_ADDR,
  input  logic [31:0]   DC_WDATA,
  output logic          DC_VALID,
  output logic [31:0]   DC_DATA,
  output logic [BW-1:0] DC_BEAT,
  output logic          DC_DONE,
  output logic          MEM_RE,
  output logic          MEM_WE,
  output logic [31:0]   MEM_ADDR,
  output logic [31:0]   MEM_DIN,
  input  logic          MEM_VALID,
  input  logic [31:0]   MEM_DOUT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IC_XFER = 2'd1;
  localparam logic [1:0] DC_XFER = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [31:0]   LINE_MASK = ~((32'd1 << BW) - 32'd1);

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic [31:0]   base;
  logic          we_l;
  logic          last_dc;

  logic ic_own;
  logic dc_own;
  logic xfer;
  logic last_beat;
  logic grant_dc;
  logic grant_ic;

  assign ic_own    = (state == IC_XFER);
  assign dc_own    = (state == DC_XFER);
  assign xfer      = ic_own || dc_own;
  assign last_beat = xfer && MEM_VALID && (beat == LAST_BEAT);

  // On a tie the requester that did not win last time takes the port.
  assign grant_dc = DC_REQ && (!IC_REQ || !last_dc);
  assign grant_ic = IC_REQ && (!DC_REQ ||  last_dc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      beat    <= '0;
      base    <= '0;
      we_l    <= 1'b0;
      last_dc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dc) begin
            state   <= DC_XFER;
            base    <= DC_ADDR & LINE_MASK;
            we_l    <= DC_WE;
            beat    <= '0;
            last_dc <= 1'b1;
          end else if (grant_ic) begin
            state   <= IC_XFER;
            base    <= IC_ADDR & LINE_MASK;
            we_l    <= 1'b0;
            beat    <= '0;
            last_dc <= 1'b0;
          end
        end
        IC_XFER, DC_XFER: begin
          // The last beat leaves the transfer state, so the counter never wraps inside a burst.
          if (last_beat) begin
            state <= GAP;
            beat  <= '0;
          end else if (MEM_VALID) begin
            beat <= beat + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Enables depend on registered state only, so requester activity cannot glitch them.
  assign MEM_RE   = ic_own || (dc_own && !we_l);
  assign MEM_WE   = dc_own && we_l;
  assign MEM_ADDR = xfer ? (base | {{(32-BW){1'b0}}, beat}) : 32'd0;
  assign MEM_DIN  = (dc_own && we_l) ? DC_WDATA : 32'd0;

  assign IC_VALID = ic_own && MEM_VALID;
  assign IC_DATA  = ic_own ? MEM_DOUT : 32'd0;
  assign IC_BEAT  = ic_own ? beat : '0;
  assign IC_DONE  = ic_own && last_beat;

  assign DC_VALID = dc_own && MEM_VALID;
  assign DC_DATA  = dc_own ? MEM_DOUT : 32'd0;
  assign DC_BEAT  = dc_own ? beat : '0;
  assign DC_DONE  = dc_own && last_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written delayed-memory burst.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_we, mem_valid;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_dout;
  logic        ic_valid, ic_done, dc_valid, dc_done, mem_re, mem_we;
  logic [1:0]  ic_beat, dc_beat;
  logic [31:0] ic_data, dc_data, mem_addr, mem_din;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Write requester supplies the word for the beat the arbiter is currently on.
  assign dc_wdata = 32'hD000_0000 | 32'(dc_beat);

  mem_arbiter #(.BURST_LEN(4)) dut (
    .CLK(clk), .RST(rst),
    .IC_REQ(ic_req), .IC_ADDR(ic_addr), .IC_VALID(ic_valid), .IC_DATA(ic_data),
    .IC_BEAT(ic_beat), .IC_DONE(ic_done),
    .DC_REQ(dc_req), .DC_WE(dc_we), .DC_ADDR(dc_addr), .DC_WDATA(dc_wdata),
    .DC_VALID(dc_valid), .DC_DATA(dc_data), .DC_BEAT(dc_beat), .DC_DONE(dc_done),
    .MEM_RE(mem_re), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_DIN(mem_din),
    .MEM_VALID(mem_valid), .MEM_DOUT(mem_dout)
  );

  typedef struct {
    string       name;
    logic        rst, icr, dcr, dcwe, mv;
    logic [31:0] ica, dca, dout;
    logic [1:0]  own;   // 0 none, 1 instruction cache, 2 data cache
    logic        v, d, re, we;
    logic [1:0]  b;
    logic [31:0] addr, din;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input int r, icr, ica, dcr, dcwe, dca, mv, dout,
                     input int own, v, b, d, re, we, addr, din);
    vec_t x;
    x.name = n;   x.rst = r[0];   x.icr = icr[0]; x.ica = ica;
    x.dcr = dcr[0]; x.dcwe = dcwe[0]; x.dca = dca; x.mv = mv[0]; x.dout = dout;
    x.own = own[1:0]; x.v = v[0]; x.b = b[1:0]; x.d = d[0];
    x.re = re[0]; x.we = we[0]; x.addr = addr; x.din = din;
    vecs.push_back(x);
  endtask

  task automatic chk(input string n, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", n, idx, act, exp);
    end
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_re"},   0, 32'(mem_re), 32'd0);
    chk({n, "_we"},   0, 32'(mem_we), 32'd0);
    chk({n, "_addr"}, 0, mem_addr, 32'd0);
    chk({n, "_icv"},  0, 32'(ic_valid), 32'd0);
    chk({n, "_icd"},  0, 32'(ic_done), 32'd0);
    chk({n, "_dcv"},  0, 32'(dc_valid), 32'd0);
  endtask

  initial begin
    vec_t x;
    logic icown, dcown;
    int   re_cyc, nb;
    bit   seen_done;

    rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_valid = 0;
    ic_addr = 0; dc_addr = 0; mem_dout = 0;

    //     name          rst icr ica     dcr we dca    mv dout        own v b d re we addr       din
    add("idle_mv",      0, 0, 0,      0, 0, 0,      1, 32'h55,     0, 0,0,0, 0, 0, 0,         0);
    add("dcw_req",      0, 0, 0,      1, 1, 32'h22, 0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("dcw_wait",     0, 0, 0,      1, 1, 32'h22, 0, 32'h1000,   2, 0,0,0, 0, 1, 32'h20,    32'hD0000000);
    add("dcw_b0",       0, 0, 0,      1, 1, 32'h22, 1, 32'h1001,   2, 1,0,0, 0, 1, 32'h20,    32'hD0000000);
    add("dcw_b1",       0, 0, 0,      1, 1, 32'h22, 1, 32'h1002,   2, 1,1,0, 0, 1, 32'h21,    32'hD0000001);
    add("dcw_hold",     0, 0, 0,      1, 1, 32'h22, 0, 32'h1003,   2, 0,2,0, 0, 1, 32'h22,    32'hD0000002);
    add("dcw_b2",       0, 0, 0,      1, 1, 32'h22, 1, 32'h1004,   2, 1,2,0, 0, 1, 32'h22,    32'hD0000002);
    add("dcw_b3",       0, 0, 0,      1, 1, 32'h22, 1, 32'h1005,   2, 1,3,1, 0, 1, 32'h23,    32'hD0000003);
    add("dcw_gap",      0, 0, 0,      0, 0, 0,      1, 32'h1006,   0, 0,0,0, 0, 0, 0,         0);
    add("dcw_idle",     0, 0, 0,      0, 0, 0,      0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("rst_idle",     1, 0, 0,      0, 0, 0,      0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("tie_req",      0, 1, 32'h40, 1, 0, 32'h83, 0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("tie_dc_b0",    0, 1, 32'h40, 1, 0, 32'h83, 1, 32'hA0,     2, 1,0,0, 1, 0, 32'h80,    0);
    add("tie_dc_b1",    0, 1, 32'h40, 1, 0, 32'h83, 1, 32'hA1,     2, 1,1,0, 1, 0, 32'h81,    0);
    add("tie_dc_b2",    0, 1, 32'h40, 1, 0, 32'h83, 1, 32'hA2,     2, 1,2,0, 1, 0, 32'h82,    0);
    add("tie_dc_b3",    0, 1, 32'h40, 1, 0, 32'h83, 1, 32'hA3,     2, 1,3,1, 1, 0, 32'h83,    0);
    add("tie_gap",      0, 1, 32'h40, 0, 0, 0,      1, 32'hA4,     0, 0,0,0, 0, 0, 0,         0);
    add("tie_idle",     0, 1, 32'h40, 0, 0, 0,      0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("ic_b0",        0, 1, 32'h40, 1, 0, 32'h84, 1, 32'hB0,     1, 1,0,0, 1, 0, 32'h40,    0);
    add("ic_b1",        0, 1, 32'h40, 1, 0, 32'h84, 1, 32'hB1,     1, 1,1,0, 1, 0, 32'h41,    0);
    add("ic_b2",        0, 1, 32'h40, 1, 0, 32'h84, 1, 32'hB2,     1, 1,2,0, 1, 0, 32'h42,    0);
    add("ic_b3",        0, 1, 32'h40, 1, 0, 32'h84, 1, 32'hB3,     1, 1,3,1, 1, 0, 32'h43,    0);
    add("tie2_gap",     0, 1, 32'h40, 1, 0, 32'h84, 0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("tie2_idle",    0, 1, 32'h40, 1, 0, 32'h84, 0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("dcdrop_w0",    0, 1, 32'h40, 0, 0, 32'h84, 0, 32'hC9,     2, 0,0,0, 1, 0, 32'h84,    0);
    add("dcdrop_w1",    0, 1, 32'h40, 0, 0, 32'h84, 0, 32'hC8,     2, 0,0,0, 1, 0, 32'h84,    0);
    add("dcdrop_b0",    0, 1, 32'h40, 0, 0, 32'h84, 1, 32'hC0,     2, 1,0,0, 1, 0, 32'h84,    0);
    add("dcdrop_b1",    0, 1, 32'h40, 0, 0, 32'h84, 1, 32'hC1,     2, 1,1,0, 1, 0, 32'h85,    0);
    add("dcdrop_b2",    0, 1, 32'h40, 0, 0, 32'h84, 1, 32'hC2,     2, 1,2,0, 1, 0, 32'h86,    0);
    add("dcdrop_b3",    0, 1, 32'h40, 0, 0, 32'h84, 1, 32'hC3,     2, 1,3,1, 1, 0, 32'h87,    0);
    add("gap3",         0, 1, 32'h40, 0, 0, 0,      0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("idle3",        0, 1, 32'h40, 0, 0, 0,      0, 0,          0, 0,0,0, 0, 0, 0,         0);
    add("line1_b0",     0, 1, 32'h40, 0, 0, 0,      1, 32'hE0,     1, 1,0,0, 1, 0, 32'h40,    0);
    add("line1_b1",     0, 1, 32'h40, 0, 0, 0,      1, 32'hE1,     1, 1,1,0, 1, 0, 32'h41,    0);
    add("line1_b2",     0, 1, 32'h40, 0, 0, 0,      1, 32'hE2,     1, 1,2,0, 1, 0, 32'h42,    0);
    add("line1_b3",     0, 1, 32'h40, 0, 0, 0,      1, 32'hE3,     1, 1,3,1, 1, 0, 32'h43,    0);
    add("line_gap",     0, 1, 32'h40, 0, 0, 0,      1, 32'hE4,     0, 0,0,0, 0, 0, 0,         0);
    add("line_idle",    0, 1, 32'h40, 0, 0, 0,      1, 32'hE5,     0, 0,0,0, 0, 0, 0,         0);
    add("line2_wait",   0, 1, 32'h40, 0, 0, 0,      0, 0,          1, 0,0,0, 1, 0, 32'h40,    0);
    add("line2_b0",     0, 1, 32'h40, 0, 0, 0,      1, 32'hF0,     1, 1,0,0, 1, 0, 32'h40,    0);
    add("line2_rst_b1", 1, 1, 32'h40, 0, 0, 0,      1, 32'hF1,     1, 1,1,0, 1, 0, 32'h41,    0);
    add("post_rst0",    0, 0, 0,      0, 0, 0,      1, 32'hF2,     0, 0,0,0, 0, 0, 0,         0);
    add("post_rst1",    0, 0, 0,      0, 0, 0,      1, 32'hF3,     0, 0,0,0, 0, 0, 0,         0);
    add("post_rst2",    0, 0, 0,      0, 0, 0,      0, 0,          0, 0,0,0, 0, 0, 0,         0);

    // Reset state with all requests low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_ic_beat", 0, 32'(ic_beat), 32'd0);
    chk("reset_dc_beat", 0, 32'(dc_beat), 32'd0);
    chk("reset_din",     0, mem_din, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      x = vecs[i];
      @(posedge clk); #1;
      rst = x.rst; ic_req = x.icr; ic_addr = x.ica; dc_req = x.dcr; dc_we = x.dcwe;
      dc_addr = x.dca; mem_valid = x.mv; mem_dout = x.dout;
      @(negedge clk);
      icown = (x.own == 2'd1);
      dcown = (x.own == 2'd2);
      chk({x.name, ".IC_VALID"}, i, 32'(ic_valid), 32'(icown && x.v));
      chk({x.name, ".IC_BEAT"},  i, 32'(ic_beat),  icown ? 32'(x.b) : 32'd0);
      chk({x.name, ".IC_DONE"},  i, 32'(ic_done),  32'(icown && x.d));
      chk({x.name, ".IC_DATA"},  i, ic_data,       icown ? x.dout : 32'd0);
      chk({x.name, ".DC_VALID"}, i, 32'(dc_valid), 32'(dcown && x.v));
      chk({x.name, ".DC_BEAT"},  i, 32'(dc_beat),  dcown ? 32'(x.b) : 32'd0);
      chk({x.name, ".DC_DONE"},  i, 32'(dc_done),  32'(dcown && x.d));
      chk({x.name, ".DC_DATA"},  i, dc_data,       dcown ? x.dout : 32'd0);
      chk({x.name, ".MEM_RE"},   i, 32'(mem_re),   32'(x.re));
      chk({x.name, ".MEM_WE"},   i, 32'(mem_we),   32'(x.we));
      chk({x.name, ".MEM_ADDR"}, i, mem_addr,      x.addr);
      chk({x.name, ".MEM_DIN"},  i, mem_din,       x.din);
    end

    // Instruction line read at 0x105 against a memory that waits 10 cycles before streaming.
    @(posedge clk); #1;
    rst = 0; dc_req = 0; ic_req = 1; ic_addr = 32'h105; mem_valid = 0; mem_dout = 0;
    re_cyc = 0; nb = 0; seen_done = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      @(posedge clk); #1;
      if (mem_re) re_cyc++;
      mem_valid = (re_cyc > 10);
      mem_dout  = 32'h7700 + nb;
      @(negedge clk);
      if (mem_valid) begin
        chk("dly_re",    nb, 32'(mem_re),   32'd1);
        chk("dly_we",    nb, 32'(mem_we),   32'd0);
        chk("dly_addr",  nb, mem_addr,      32'h104 + nb);
        chk("dly_beat",  nb, 32'(ic_beat),  32'(nb));
        chk("dly_valid", nb, 32'(ic_valid), 32'd1);
        chk("dly_data",  nb, ic_data,       32'h7700 + nb);
        chk("dly_done",  nb, 32'(ic_done),  32'(nb == 3));
        if (ic_done) seen_done = 1;
        nb++;
      end else if (re_cyc > 0) begin
        chk("dly_wait_valid", re_cyc, 32'(ic_valid), 32'd0);
        chk("dly_wait_addr",  re_cyc, mem_addr,      32'h104);
      end
    end
    chk("dly_done_seen", 0, 32'(seen_done), 32'd1);
    chk("dly_beats",     0, 32'(nb),        32'd4);
    chk("dly_delay",     0, 32'(re_cyc),    32'd14);

    @(posedge clk); #1;
    ic_req = 0; mem_valid = 1;
    @(negedge clk);
    chk_quiet("dly_gap");
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("dly_idle");
    @(posedge clk); #1;
    mem_valid = 0;
    @(negedge clk);
    chk_quiet("dly_stay_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: words per line transfer; power of two, at least 2.
REQ-002 SHALL have parameter BW, default $clog2(BURST_LEN): beat index width.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port IC_REQ, input, 1: instruction-cache line-read request, held until IC_DONE.
REQ-006 SHALL have port IC_ADDR, input, 32: instruction-cache word address, held with IC_REQ.
REQ-007 SHALL have port IC_VALID, output, 1: IC_DATA beat valid this cycle.
REQ-008 SHALL have port IC_DATA, output, 32: read beat to instruction cache.
REQ-009 SHALL have port IC_BEAT, output, BW: index of the current instruction-cache beat.
REQ-010 SHALL have port IC_DONE, output, 1: one-cycle pulse on the last instruction-cache beat.
REQ-011 SHALL have port DC_REQ, input, 1: data-cache line request, held until DC_DONE.
REQ-012 SHALL have port DC_WE, input, 1: 1 = line writeback, 0 = line fill; held with DC_REQ.
REQ-013 SHALL have port DC_ADDR, input, 32: data-cache word address, held with DC_REQ.
REQ-014 SHALL have port DC_WDATA, input, 32: writeback word for index DC_BEAT, driven combinationally by the requester.
REQ-015 SHALL have port DC_VALID, output, 1: beat accepted or delivered this cycle.
REQ-016 SHALL have port DC_DATA, output, 32: read beat to data cache.
REQ-017 SHALL have port DC_BEAT, output, BW: index of the current data-cache beat.
REQ-018 SHALL have port DC_DONE, output, 1: one-cycle pulse on the last data-cache beat.
REQ-019 SHALL have port MEM_RE, output, 1: main-memory read enable.
REQ-020 SHALL have port MEM_WE, output, 1: main-memory write enable.
REQ-021 SHALL have port MEM_ADDR, output, 32: main-memory word address.
REQ-022 SHALL have port MEM_DIN, output, 32: main-memory write data.
REQ-023 SHALL have port MEM_VALID, input, 1: memory beat strobe.
REQ-024 SHALL have port MEM_DOUT, input, 32: memory read data.

Function
REQ-025 SHALL implement state machine with states IDLE, IC_XFER, DC_XFER and GAP.
REQ-026 IDLE: if only one REQ is high, SHALL grant it at the next edge.
REQ-027 IDLE, both REQs high: SHALL grant the requester not granted last (round-robin via a last-grant register).
REQ-028 At grant SHALL latch: base = ADDR with low BW bits cleared, DC_WE into we_l, and beat counter = 0.
REQ-029 IC_XFER: MEM_RE SHALL be 1 and MEM_WE SHALL be 0.
REQ-030 DC_XFER: MEM_RE SHALL equal !we_l and MEM_WE SHALL equal we_l.
REQ-031 IDLE and GAP: MEM_RE and MEM_WE SHALL be 0.
REQ-032 MEM_RE and MEM_WE SHALL be decoded from registered state only, glitch-free, and held for the whole transaction regardless of REQ changes.
REQ-033 MEM_ADDR SHALL equal base | beat during a transfer, else 0.
REQ-034 The beat counter SHALL increment on each cycle with MEM_VALID=1 in a transfer state; it SHALL not increment on cycles with MEM_VALID=0, including the delay phase.
REQ-035 IC_VALID SHALL equal (state==IC_XFER && MEM_VALID), and DC_VALID likewise for DC_XFER.
REQ-036 IC_DATA and DC_DATA SHALL pass MEM_DOUT combinationally, zero-latency.
REQ-037 IC_BEAT and DC_BEAT SHALL equal the beat counter while owned, else 0.
REQ-038 MEM_DIN SHALL equal DC_WDATA in DC_XFER with we_l=1, else 0.
REQ-039 DONE SHALL be asserted for the owner when VALID && beat==BURST_LEN-1, same cycle as the last beat.
REQ-040 On the last beat, next state SHALL be GAP for exactly one cycle with enables low, then IDLE; this guarantees memory sees a deasserted enable between transactions.
REQ-041 Minimum spacing: a new grant SHALL occur two cycles after the prior DONE.
REQ-042 MEM_VALID in IDLE or GAP SHALL be ignored: no VALID, no DONE, no count.
REQ-043 Counter wrap: BW bits SHALL be used and the last beat forces GAP, so the counter SHALL never wrap within a transaction.
REQ-044 A REQ dropped mid-transfer SHALL not abort: the transfer completes and DONE still pulses.
REQ-045 A REQ held high after DONE SHALL be treated as a new request and SHALL pass arbitration after GAP.
REQ-046 A non-granted requester SHALL see VALID=0, DONE=0 and BEAT=0 throughout.

Reset
REQ-047 RST=1 at an edge SHALL force state IDLE, beat counter 0, base 0, we_l 0 and last-grant = IC, so the data cache wins the first tie.
REQ-048 While in reset and after it, all outputs SHALL be 0.
REQ-049 Reset mid-transfer SHALL abandon the transfer with no DONE, and MEM_RE/MEM_WE SHALL be low at the cycle after the reset edge.
REQ-050 After reset, MEM_VALID pulses from the abandoned burst SHALL be ignored per REQ-042.

Verification
REQ-051 IC_REQ=1, IC_ADDR=0x105 with memory delay 10 -> MEM_RE high; MEM_ADDR 0x104..0x107 on beats 0..3; IC_DONE with beat 3; one GAP cycle; IDLE.
REQ-052 DC_REQ=1, DC_WE=1, DC_ADDR=0x20 -> MEM_WE high, MEM_RE low; MEM_DIN = DC_WDATA[beat] at addresses 0x20..0x23; DC_DONE on the fourth valid beat.
REQ-053 IC_REQ and DC_REQ raised together after reset -> DC granted first; IC granted two cycles after DC_DONE; next tie goes to DC again.
REQ-054 DC_REQ dropped during the delay phase -> MEM_RE stays high; all 4 beats are delivered; DC_DONE pulses.
REQ-055 RST pulsed during beat 1 of an IC read -> no IC_DONE; enables low the next cycle; later MEM_VALID pulses produce no IC_VALID.
REQ-056 IC_REQ held high across two lines -> exactly one GAP cycle with MEM_RE=0 between the two bursts.
